div_result_collector: RTL and testbench
=======================================

// Module: div_result_collector
// PURPOSE
//  Downstream stage of the Fibonacci divider. Captures each quotient (binary) and remainder
//  (Zeckendorf Fibonacci code) when the divider's div_done rises. Converts the remainder to binary
//  bit-serially and buffers {quot, rem_bin, rem_fib} in a small FIFO behind a valid/ready output.
// PARAMETERS
//  W      32  operand width; remainder bit k carries weight F(k+2), where F(1)=F(2)=1 (1,2,3,5,8,...)
//  DEPTH  4   FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  div_done   in   1      divider done level; may stay high for several cycles
//  out_div    in   W      divider quotient, binary
//  out_yu_shu in   W      divider remainder, Zeckendorf code
//  busy       out  1      capture register occupied (CONV or PUSH)
//  ovf        out  1      sticky: a result was dropped; cleared only by reset
//  m_valid    out  1      FIFO head valid
//  m_ready    in   1      consumer accepts the head when m_valid&&m_ready
//  m_quot     out  W      head quotient
//  m_rem_bin  out  W      head remainder, binary
//  m_rem_fib  out  W      head remainder, original Zeckendorf code
//  m_err      out  1      head remainder had adjacent 1s (tied 0 unless ZECK_CHECK_EN)
//  fifo_full  out  1      FIFO holds DEPTH entries
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; done_q=0. An in-flight result is lost.
//  Capture: start = div_done & ~done_q (done_q is div_done registered). Only the rising edge counts.
//  FSM IDLE -> CONV -> PUSH -> IDLE:
//   IDLE: on start, latch out_div and out_yu_shu; acc=0, fa=1, fb=2, k=0; go to CONV.
//   CONV: each cycle: if rem[k], acc += fa; then {fa,fb} <= {fb, fa+fb}; k++.
//     Exactly W cycles, with no early exit. fa/fb/acc are W+1 bits internally and acc is truncated to W.
//     For W=32 the maximum code 0x55555555 gives 3524577, so there is no overflow.
//   PUSH: write one FIFO entry when not full, then go to IDLE. While full, stay in PUSH (stall).
//  Latency: start sampled at edge N -> write at edge N+W+1 -> m_valid high after edge N+W+1
//   if the FIFO was empty.
//  busy=1 in CONV and PUSH. A start while busy drops the new result and sets ovf.
//   The captured result is unaffected.
//  A start in the same cycle as the PUSH write is also dropped (busy is still 1), and ovf is set.
//  FIFO: show-ahead; pointers are log2(DEPTH)+1 bits and wrap naturally.
//   full  = (wr ^ rd) == {1'b1, 0...}
//   empty = (wr == rd)
//  Simultaneous write and read on a full FIFO: the read frees the slot this cycle, so the write
//   proceeds. Read on empty: ignored. Head outputs hold while m_valid && !m_ready.
//  Zero remainder converts to 0. Zero quotient is stored unchanged.
// CONFIGURATION
//  ZECK_CHECK_EN defined: during CONV, err |= rem[k] & rem[k-1] for k>=1.
//   err is stored per entry and driven on m_err. The binary value is still the weighted sum.
//  ZECK_CHECK_EN undefined: no check logic and no err storage; m_err = 1'b0.
// STRUCTURE
//  Shared package fib_defs: W default, the state encodings (IDLE=2'd0, CONV=2'd1, PUSH=2'd2),
//   and the Fibonacci seed constants F2=1, F3=2.
//  One sub-module, div_result_fifo: parameterised width/depth show-ahead FIFO.
//   The entry is {err?, rem_fib, rem_bin, quot}.
//  Top level: edge detect, capture registers, serial converter FSM, ovf.
// TESTING
//  1. quot=7, rem=32'b1010, 1-cycle div_done, m_ready=1
//     -> m_valid at N+33; m_quot=7, m_rem_bin=7, m_rem_fib=0xA, m_err=0.
//  2. rem=0x55555555, quot=0 -> m_rem_bin=3524577; rem=0 -> m_rem_bin=0.
//  3. div_done held high 10 cycles -> exactly one entry; ovf stays 0.
//  4. m_ready=0, DEPTH=4, 5 results -> fifo_full=1 and 5th stalls in PUSH (busy=1);
//     6th start -> ovf=1; then m_ready=1 drains 5 entries in order.
//  5. ZECK_CHECK_EN, rem=32'b11 -> m_rem_bin=3, m_err=1; without macro -> m_err=0.
//  6. rst low mid-CONV -> all outputs 0 at once; next result converts correctly.

Source files
------------

// File: rtl/div_result_collector_pkg.sv
// ============================================================================
// Module      : fib_defs (package)
// Description : Shared definitions for the Fibonacci divider result path:
//               default operand width, converter state encodings and the
//               Fibonacci seed constants used by the serial converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fib_defs;

    localparam int W_DEFAULT = 32;

    // Weights of remainder bits 0 and 1: F(2) and F(3)
    localparam int F2 = 1;
    localparam int F3 = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        PUSH = 2'd2
    } fib_state_t;

endpackage

`default_nettype wire

// File: rtl/div_result_fifo.sv
// ============================================================================
// Module      : div_result_fifo
// Description : Parameterised show-ahead FIFO. Head data reads as zero while
//               empty; a read on a full FIFO frees a slot for a same-cycle write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          valid,
    output logic          full,
    output logic          wr_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign w_do_rd = rd_en & ~w_empty;
    assign wr_ok   = ~w_full | w_do_rd;
    assign w_do_wr = wr_en & wr_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // When full, the write slot is the head being read this cycle; the read sees the old word.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign valid   = ~w_empty;
    assign full    = w_full;

endmodule

`default_nettype wire

// File: rtl/div_result_collector.sv
// ============================================================================
// Module      : div_result_collector
// Description : Captures divider results on the rising edge of div_done,
//               converts the Zeckendorf remainder to binary bit-serially and
//               queues {quot, rem_bin, rem_fib} behind a valid/ready port.
//               Optional macro ZECK_CHECK_EN adds an adjacent-ones check (m_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_collector
    import fib_defs::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_done,
    input  logic [W-1:0] out_div,
    input  logic [W-1:0] out_yu_shu,
    output logic         busy,
    output logic         ovf,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_quot,
    output logic [W-1:0] m_rem_bin,
    output logic [W-1:0] m_rem_fib,
    output logic         m_err,
    output logic         fifo_full
);

    localparam int KW = $clog2(W);
`ifdef ZECK_CHECK_EN
    localparam int EW = 3*W + 1;
`else
    localparam int EW = 3*W;
`endif

    fib_state_t    r_state;
    logic          r_done_q;
    logic          r_ovf;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem_fib;
    logic [W-1:0]  r_rem_sh;
    logic [W-1:0]  r_acc;
    logic [W:0]    r_fa;
    logic [W:0]    r_fb;
    logic [KW-1:0] r_k;
`ifdef ZECK_CHECK_EN
    logic          r_err;
    logic          r_prev;
`endif

    logic          w_start;
    logic          w_wr_ok;
    logic          w_fifo_wr;
    logic [EW-1:0] w_wr_data;
    logic [EW-1:0] w_rd_data;

    assign w_start   = div_done & ~r_done_q;
    assign w_fifo_wr = (r_state == PUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_done_q  <= 1'b0;
            r_ovf     <= 1'b0;
            r_quot    <= '0;
            r_rem_fib <= '0;
            r_rem_sh  <= '0;
            r_acc     <= '0;
            r_fa      <= '0;
            r_fb      <= '0;
            r_k       <= '0;
`ifdef ZECK_CHECK_EN
            r_err     <= 1'b0;
            r_prev    <= 1'b0;
`endif
        end else begin
            r_done_q <= div_done;
            if (w_start && (r_state != IDLE)) r_ovf <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_quot    <= out_div;
                        r_rem_fib <= out_yu_shu;
                        r_rem_sh  <= out_yu_shu;
                        r_acc     <= '0;
                        r_fa      <= (W+1)'(F2);
                        r_fb      <= (W+1)'(F3);
                        r_k       <= '0;
`ifdef ZECK_CHECK_EN
                        r_err     <= 1'b0;
                        r_prev    <= 1'b0;
`endif
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    // Accumulator kept at W bits: the sum is truncated to W regardless.
                    if (r_rem_sh[0]) r_acc <= r_acc + r_fa[W-1:0];
                    r_fa     <= r_fb;
                    r_fb     <= r_fa + r_fb;
                    r_rem_sh <= r_rem_sh >> 1;
                    r_k      <= r_k + KW'(1);
`ifdef ZECK_CHECK_EN
                    r_err    <= r_err | (r_rem_sh[0] & r_prev);
                    r_prev   <= r_rem_sh[0];
`endif
                    if (r_k == KW'(W-1)) r_state <= PUSH;
                end
                PUSH: begin
                    if (w_wr_ok) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ZECK_CHECK_EN
    assign w_wr_data = {r_err, r_rem_fib, r_acc, r_quot};
    assign m_err     = w_rd_data[3*W];
`else
    assign w_wr_data = {r_rem_fib, r_acc, r_quot};
    assign m_err     = 1'b0;
`endif

    div_result_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_fifo_wr),
        .wr_data (w_wr_data),
        .rd_en   (m_ready),
        .rd_data (w_rd_data),
        .valid   (m_valid),
        .full    (fifo_full),
        .wr_ok   (w_wr_ok)
    );

    assign m_quot    = w_rd_data[W-1:0];
    assign m_rem_bin = w_rd_data[2*W-1:W];
    assign m_rem_fib = w_rd_data[3*W-1:2*W];
    assign busy      = (r_state != IDLE);
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_div_result_collector.sv
// ============================================================================
// Module      : tb_div_result_collector
// Description : Scoreboard bench for div_result_collector (W=32, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_result_collector;

    localparam int W     = 32;
    localparam int DEPTH = 4;
`ifdef ZECK_CHECK_EN
    localparam logic ADJ_ERR = 1'b1;
`else
    localparam logic ADJ_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         div_done = 1'b0;
    logic [W-1:0] out_div = '0;
    logic [W-1:0] out_yu_shu = '0;
    logic         busy;
    logic         ovf;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_quot;
    logic [W-1:0] m_rem_bin;
    logic [W-1:0] m_rem_fib;
    logic         m_err;
    logic         fifo_full;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    div_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_done   (div_done),
        .out_div    (out_div),
        .out_yu_shu (out_yu_shu),
        .busy       (busy),
        .ovf        (ovf),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_quot     (m_quot),
        .m_rem_bin  (m_rem_bin),
        .m_rem_fib  (m_rem_fib),
        .m_err      (m_err),
        .fifo_full  (fifo_full)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expectation
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_entry", m_quot, '1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("m_quot", m_quot, e.q);
                check("m_rem_bin", m_rem_bin, e.b);
                check("m_rem_fib", m_rem_fib, e.f);
                check("m_err", {31'd0, m_err}, {31'd0, e.e});
            end
        end
    end

    // Drives div_done high for len cycles; returns 1ns after the sampling edge + len-1
    task automatic issue(input logic [W-1:0] q, input logic [W-1:0] r, input int len,
                         input logic [W-1:0] bin, input logic err, input bit expect_entry);
        exp_t e;
        if (expect_entry) begin
            e.q = q; e.b = bin; e.f = r; e.e = err;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        div_done   = 1'b1;
        out_div    = q;
        out_yu_shu = r;
        repeat (len) @(posedge clk);
        #1 div_done = 1'b0;
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check({name, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((busy || m_valid || sb.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, {31'd0, (busy || m_valid || sb.size() != 0)}, 32'd0);
    endtask

    initial begin
        int lat;
        #1 #1;
        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_m_quot", m_quot, 32'd0);
        check("rst_m_rem_bin", m_rem_bin, 32'd0);
        check("rst_m_rem_fib", m_rem_fib, 32'd0);
        check("rst_m_err", {31'd0, m_err}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // 1: basic conversion and latency: 0b1010 -> 2 + 5 = 7
        issue(32'd7, 32'b1010, 1, 32'd7, 1'b0, 1'b1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!m_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t1_latency", lat, 32'd33);
        wait_drained("t1");

        // 2: maximum Zeckendorf code and zero remainder / zero quotient
        issue(32'd0, 32'h5555_5555, 1, 32'd3524577, 1'b0, 1'b1);
        wait_drained("t2a");
        issue(32'd5, 32'd0, 1, 32'd0, 1'b0, 1'b1);
        wait_drained("t2b");

        // 3: div_done held 10 cycles -> single entry; bits 2,5 -> 3 + 13 = 16
        issue(32'd9, 32'b100100, 10, 32'd16, 1'b0, 1'b1);
        wait_drained("t3");
        check("t3_ovf", {31'd0, ovf}, 32'd0);

        // 4: back-pressure, stall in PUSH, overflow, ordered drain
        #1 m_ready = 1'b0;
        issue(32'd100, 32'h01, 1, 32'd1, 1'b0, 1'b1); wait_not_busy("t4_0");
        issue(32'd101, 32'h02, 1, 32'd2, 1'b0, 1'b1); wait_not_busy("t4_1");
        issue(32'd102, 32'h04, 1, 32'd3, 1'b0, 1'b1); wait_not_busy("t4_2");
        issue(32'd103, 32'h08, 1, 32'd5, 1'b0, 1'b1); wait_not_busy("t4_3");
        issue(32'd104, 32'h10, 1, 32'd8, 1'b0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("t4_fifo_full", {31'd0, fifo_full}, 32'd1);
        check("t4_busy_stall", {31'd0, busy}, 32'd1);
        check("t4_m_valid", {31'd0, m_valid}, 32'd1);
        check("t4_ovf_before", {31'd0, ovf}, 32'd0);
        check("t4_head_quot", m_quot, 32'd100);
        issue(32'd999, 32'h01, 1, 32'd1, 1'b0, 1'b0);
        check("t4_ovf_after", {31'd0, ovf}, 32'd1);
        m_ready = 1'b1;
        wait_drained("t4");
        check("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

        // 5: adjacent ones -> weighted sum 1 + 2 = 3, err only with the check enabled
        issue(32'd11, 32'b11, 1, 32'd3, ADJ_ERR, 1'b1);
        wait_drained("t5");

        // 6: asynchronous reset mid-conversion, then a clean result (1 + 5 = 6)
        issue(32'd77, 32'h5555_5555, 1, 32'd3524577, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ovf", {31'd0, ovf}, 32'd0);
        check("t6_m_valid", {31'd0, m_valid}, 32'd0);
        check("t6_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("t6_m_quot", m_quot, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        issue(32'd3, 32'b1001, 1, 32'd6, 1'b0, 1'b1);
        wait_drained("t6");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
